// File: rtl/parking_pkg.sv
// Shared parking-lot definitions: direction FSM state encoding and sensor debounce default.
// Also imported by the lot occupancy counter.
package parking_pkg;

    localparam logic [15:0] DEBOUNCE_DEFAULT = 16'd1000;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_EN_A     = 3'd1;
    localparam logic [2:0] ST_EN_AB    = 3'd2;
    localparam logic [2:0] ST_EN_B     = 3'd3;
    localparam logic [2:0] ST_EX_B     = 3'd4;
    localparam logic [2:0] ST_EX_AB    = 3'd5;
    localparam logic [2:0] ST_EX_A     = 3'd6;
    localparam logic [2:0] ST_WAIT_CLR = 3'd7;

    typedef enum logic [2:0] {
        IDLE     = ST_IDLE,
        EN_A     = ST_EN_A,
        EN_AB    = ST_EN_AB,
        EN_B     = ST_EN_B,
        EX_B     = ST_EX_B,
        EX_AB    = ST_EX_AB,
        EX_A     = ST_EX_A,
        WAIT_CLR = ST_WAIT_CLR
    } dir_state_t;

endpackage

// File: rtl/sensor_debounce.sv
// Purpose: 2-flop synchronizer plus optional stability filter (CAR_DIRECTION_DEBOUNCE_EN) for one photo-sensor.
// Latency: 2 cycles sync, plus DEBOUNCE_CYCLES when the filter is built; no backpressure (free-running).
module sensor_debounce
    import parking_pkg::*;
#(
    parameter logic [15:0] DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic filt
);

    logic [1:0] sync_q;
    logic       sync_bit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= 2'b00;
        else        sync_q <= {sync_q[0], raw};
    end

    assign sync_bit = sync_q[1];

`ifdef CAR_DIRECTION_DEBOUNCE_EN
    logic [15:0] cnt;
    logic        filt_q;

    // cnt holds how many consecutive cycles the synchronized bit has disagreed with filt_q
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= 16'd0;
            filt_q <= 1'b0;
        end else if (sync_bit == filt_q) begin
            cnt <= 16'd0;
        end else if (({1'b0, cnt} + 17'd1) >= {1'b0, DEBOUNCE_CYCLES}) begin
            filt_q <= sync_bit;
            cnt    <= 16'd0;
        end else if (cnt != 16'hFFFF) begin
            cnt <= cnt + 16'd1;
        end
    end

    assign filt = filt_q;
`else
    logic unused_cfg;
    assign unused_cfg = ^DEBOUNCE_CYCLES;
    assign filt       = sync_bit;
`endif

endmodule

// File: rtl/car_direction_detector.sv
// Purpose: classify A/B beam-break sequences into entry, exit or error pulses; filter built with CAR_DIRECTION_DEBOUNCE_EN.
// Latency: filtered edge to pulse is 1 cycle (registered outputs); no backpressure, pulses are single-cycle.
module car_direction_detector
    import parking_pkg::*;
#(
    parameter logic [15:0] DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic CLK100MHZ,
    input  logic reset_n,
    input  logic A,
    input  logic B,
    output logic car_enter,
    output logic car_exit,
    output logic seq_error,
    output logic busy
);

    logic       fa;
    logic       fb;
    logic [1:0] ab;

    dir_state_t state;
    dir_state_t nxt;
    logic       enter_nxt;
    logic       exit_nxt;
    logic       err_nxt;

    sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
        .clk   (CLK100MHZ),
        .rst_n (reset_n),
        .raw   (A),
        .filt  (fa)
    );

    sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
        .clk   (CLK100MHZ),
        .rst_n (reset_n),
        .raw   (B),
        .filt  (fb)
    );

    assign ab = {fa, fb};

    always_ff @(posedge CLK100MHZ or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            car_enter <= 1'b0;
            car_exit  <= 1'b0;
            seq_error <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= nxt;
            car_enter <= enter_nxt;
            car_exit  <= exit_nxt;
            seq_error <= err_nxt;
            busy      <= (nxt != IDLE);
        end
    end

    // Unlisted codes in each state mean "hold"; anything flagged err_nxt is redirected below.
    always_comb begin
        nxt       = state;
        enter_nxt = 1'b0;
        exit_nxt  = 1'b0;
        err_nxt   = 1'b0;
        unique case (state)
            IDLE: case (ab)
                2'b10:   nxt = EN_A;
                2'b01:   nxt = EX_B;
                2'b11:   err_nxt = 1'b1;
                default: ;
            endcase
            EN_A: case (ab)
                2'b11:   nxt = EN_AB;
                2'b00:   nxt = IDLE;
                2'b01:   err_nxt = 1'b1;
                default: ;
            endcase
            EN_AB: case (ab)
                2'b01:   nxt = EN_B;
                2'b10:   nxt = EN_A;
                2'b00:   err_nxt = 1'b1;
                default: ;
            endcase
            EN_B: case (ab)
                2'b00: begin
                    nxt       = IDLE;
                    enter_nxt = 1'b1;
                end
                2'b11:   nxt = EN_AB;
                2'b10:   err_nxt = 1'b1;
                default: ;
            endcase
            EX_B: case (ab)
                2'b11:   nxt = EX_AB;
                2'b00:   nxt = IDLE;
                2'b10:   err_nxt = 1'b1;
                default: ;
            endcase
            EX_AB: case (ab)
                2'b10:   nxt = EX_A;
                2'b01:   nxt = EX_B;
                2'b00:   err_nxt = 1'b1;
                default: ;
            endcase
            EX_A: case (ab)
                2'b00: begin
                    nxt      = IDLE;
                    exit_nxt = 1'b1;
                end
                2'b11:   nxt = EX_AB;
                2'b01:   err_nxt = 1'b1;
                default: ;
            endcase
            WAIT_CLR: begin
                if (ab == 2'b00) nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
        if (err_nxt) nxt = WAIT_CLR;
    end

endmodule

// File: tb/tb_car_direction_detector.sv
// Randomized and directed bench for car_direction_detector against a path-walking reference model.
module tb_car_direction_detector;

    localparam int N = 4;
`ifdef CAR_DIRECTION_DEBOUNCE_EN
    localparam bit FILT = 1'b1;
    localparam int LAT  = N + 3;
`else
    localparam bit FILT = 1'b0;
    localparam int LAT  = 3;
`endif

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic a       = 1'b0;
    logic b       = 1'b0;
    logic car_enter;
    logic car_exit;
    logic seq_error;
    logic busy;

    always #5 clk = ~clk;

    car_direction_detector #(.DEBOUNCE_CYCLES(16'd4)) dut (
        .CLK100MHZ (clk),
        .reset_n   (reset_n),
        .A         (a),
        .B         (b),
        .car_enter (car_enter),
        .car_exit  (car_exit),
        .seq_error (seq_error),
        .busy      (busy)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: sensors as delay lines plus stability filter, direction as a walk along path tables.
    bit [1:0] entry_path [5] = '{2'b00, 2'b10, 2'b11, 2'b01, 2'b00};
    bit [1:0] exit_path  [5] = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b00};

    bit m_sa1 = 0, m_sa2 = 0, m_sb1 = 0, m_sb2 = 0, m_fa = 0, m_fb = 0;
    int run_a = 0, run_b = 0;
    int dir = 0;   // 0 idle, 1 entering, 2 exiting, 3 waiting for clear
    int pos = 0;
    bit e_enter = 0, e_exit = 0, e_err = 0, e_busy = 0;

    function automatic bit [1:0] path_at(input int d, input int p);
        return (d == 1) ? entry_path[p] : exit_path[p];
    endfunction

    function automatic void filt_step(input bit s, inout bit f, inout int run);
        if (s != f) begin
            run++;
            if (run >= N) begin
                f   = s;
                run = 0;
            end
        end else begin
            run = 0;
        end
    endfunction

    function automatic void fsm_step(input bit [1:0] v);
        e_enter = 0;
        e_exit  = 0;
        e_err   = 0;
        if (dir == 3) begin
            if (v == 2'b00) dir = 0;
        end else if (dir == 0) begin
            if (v == 2'b10) begin dir = 1; pos = 1; end
            else if (v == 2'b01) begin dir = 2; pos = 1; end
            else if (v != 2'b00) begin dir = 3; e_err = 1; end
        end else if (v == path_at(dir, pos)) begin
            // holding position
        end else if (v == path_at(dir, pos + 1)) begin
            pos++;
            if (pos == 4) begin
                if (dir == 1) e_enter = 1;
                else          e_exit  = 1;
                dir = 0;
                pos = 0;
            end
        end else if (v == path_at(dir, pos - 1)) begin
            pos--;
            if (pos == 0) dir = 0;
        end else begin
            dir   = 3;
            e_err = 1;
        end
        e_busy = (dir != 0);
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_sa1 = 0; m_sa2 = 0; m_sb1 = 0; m_sb2 = 0; m_fa = 0; m_fb = 0;
            run_a = 0; run_b = 0; dir = 0; pos = 0;
            e_enter = 0; e_exit = 0; e_err = 0; e_busy = 0;
        end else begin
            fsm_step(FILT ? {m_fa, m_fb} : {m_sa2, m_sb2});
            if (FILT) begin
                filt_step(m_sa2, m_fa, run_a);
                filt_step(m_sb2, m_fb, run_b);
            end
            m_sa2 = m_sa1; m_sa1 = a;
            m_sb2 = m_sb1; m_sb1 = b;
        end
    end

    int n_enter = 0, n_exit = 0, n_err = 0, n_busy = 0;

    always @(negedge clk) begin
        check("car_enter", car_enter, e_enter);
        check("car_exit", car_exit, e_exit);
        check("seq_error", seq_error, e_err);
        check("busy", busy, e_busy);
        check("enter_exit_excl", car_enter & car_exit, 0);
        n_enter += car_enter;
        n_exit  += car_exit;
        n_err   += seq_error;
        n_busy  += busy;
    end

    // Driver sits at negedge+2 between calls.
    task automatic drive(input bit [1:0] v, input int cycles);
        {a, b} = v;
        repeat (cycles) @(negedge clk);
        #2;
    endtask

    task automatic expect_deltas(input string tag, input int se, input int sx, input int sr,
                                 input int de, input int dx, input int dr);
        check({tag, "_enter_cnt"}, n_enter - se, de);
        check({tag, "_exit_cnt"}, n_exit - sx, dx);
        check({tag, "_err_cnt"}, n_err - sr, dr);
    endtask

    initial begin
        int se, sx, sr, sb, k;
        repeat (3) @(negedge clk);
        #2;
        check("rst_enter", car_enter, 0);
        check("rst_exit", car_exit, 0);
        check("rst_err", seq_error, 0);
        check("rst_busy", busy, 0);
        reset_n = 1'b1;
        drive(2'b00, 5);

        // entry with latency measurement of the final release
        se = n_enter; sx = n_exit; sr = n_err;
        drive(2'b00, 10); drive(2'b10, 10); drive(2'b11, 10); drive(2'b01, 10);
        {a, b} = 2'b00;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!car_enter && k < 50);
        #2;
        check("enter_latency", k, LAT);
        drive(2'b00, 10);
        expect_deltas("entry", se, sx, sr, 1, 0, 0);
        check("entry_busy_after", busy, 0);

        // exit
        se = n_enter; sx = n_exit; sr = n_err;
        drive(2'b01, 10); drive(2'b11, 10); drive(2'b10, 10); drive(2'b00, 20);
        expect_deltas("exit", se, sx, sr, 0, 1, 0);
        check("exit_busy_after", busy, 0);

        // short glitch on A
        se = n_enter; sx = n_exit; sr = n_err; sb = n_busy;
        drive(2'b10, 3); drive(2'b00, 15);
        expect_deltas("bounce", se, sx, sr, 0, 0, 0);
        if (FILT) check("bounce_busy_cycles", n_busy - sb, 0);

        // both beams at once
        se = n_enter; sx = n_exit; sr = n_err;
        drive(2'b11, 10);
        check("illegal_err_cnt", n_err - sr, 1);
        check("illegal_busy_held", busy, 1);
        drive(2'b00, 15);
        check("illegal_busy_clear", busy, 0);
        expect_deltas("illegal", se, sx, sr, 0, 0, 1);

        // aborted partial entry
        se = n_enter; sx = n_exit; sr = n_err;
        drive(2'b10, 10); drive(2'b00, 15);
        expect_deltas("abort", se, sx, sr, 0, 0, 0);
        check("abort_busy", busy, 0);

        // reset mid-sequence
        drive(2'b10, 10); drive(2'b11, 10);
        check("pre_reset_busy", busy, 1);
        reset_n = 1'b0;
        #1;
        check("midrst_enter", car_enter, 0);
        check("midrst_exit", car_exit, 0);
        check("midrst_err", seq_error, 0);
        check("midrst_busy", busy, 0);
        {a, b} = 2'b00;
        repeat (3) @(negedge clk);
        #2;
        reset_n = 1'b1;
        se = n_enter; sx = n_exit; sr = n_err;
        drive(2'b00, 20);
        expect_deltas("post_reset", se, sx, sr, 0, 0, 0);

        // random sensor activity with occasional resets
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                reset_n = 1'b0;
                @(negedge clk);
                #2;
                reset_n = 1'b1;
            end
            drive(2'($urandom_range(0, 3)), $urandom_range(1, 12));
        end
        drive(2'b00, 20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
